// File: rtl/decim_channel_scheduler_pkg.sv
// decim_pkg: shared sizing helpers and chain-wide defaults for the decimating channel scheduler
package decim_pkg;
   localparam int DEFAULT_DECIMATE_FACTOR = 4;
   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/decim_channel_scheduler_if.sv
// decim_channel_scheduler_if: per-channel sample inputs and shared tagged output stream
interface decim_channel_scheduler_if #(
   parameter int NUM_CH = 4,
   parameter int WIDTH  = 16
);
   localparam int CH_W = decim_pkg::ch_w(NUM_CH);
   logic [NUM_CH-1:0]       ch_valid;
   logic [NUM_CH*WIDTH-1:0] ch_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [WIDTH-1:0]        out_data;
   logic [CH_W-1:0]         out_ch;
   modport master (output ch_valid, ch_data, out_ready, input out_valid, out_data, out_ch);
   modport slave  (input ch_valid, ch_data, out_ready, output out_valid, out_data, out_ch);
endinterface

// File: rtl/decim_channel_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting after last_grant; pointer lives in the parent
module rr_arbiter import decim_pkg::*; #(
   parameter int NUM_CH = 4,
   localparam int CH_W  = ch_w(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [CH_W-1:0]   last_grant,
   input  logic              grant_en,
   output logic [NUM_CH-1:0] gnt,
   output logic [CH_W-1:0]   gnt_idx,
   output logic              gnt_any
);
   logic [CH_W-1:0] c;
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      c       = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         c = CH_W'((int'(last_grant) + k) % NUM_CH);
         if (grant_en && !gnt_any && req[c]) begin
            gnt[c]  = 1'b1;
            gnt_idx = c;
            gnt_any = 1'b1;
         end
      end
   end
endmodule

// File: rtl/decim_channel_scheduler.sv
// decim_channel_scheduler: per-channel decimate-by-M into one-entry buffers, round-robin drained to one output
module decim_channel_scheduler import decim_pkg::*; #(
   parameter int NUM_CH          = 4,
   parameter int DECIMATE_FACTOR = DEFAULT_DECIMATE_FACTOR,
   parameter int WIDTH           = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 clear_ovf,
   output logic [NUM_CH-1:0]    overflow,
   decim_channel_scheduler_if.slave bus
);
   localparam int CH_W = ch_w(NUM_CH);
   localparam int PW   = (DECIMATE_FACTOR > 1) ? $clog2(DECIMATE_FACTOR) : 1;
   logic [PW-1:0]    phase [NUM_CH];
   logic [WIDTH-1:0] hold  [NUM_CH];
   logic [NUM_CH-1:0] full, keep, wr, ovf_ev, gnt;
   logic [CH_W-1:0]   last_grant, gnt_idx;
   logic              gnt_any, out_free;
   assign out_free = !bus.out_valid || bus.out_ready;
   rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
      .req(full), .last_grant(last_grant), .grant_en(out_free),
      .gnt(gnt), .gnt_idx(gnt_idx), .gnt_any(gnt_any)
   );
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign keep[i]   = enable && bus.ch_valid[i] && phase[i] == '0;
      // a drain in the same cycle frees the slot, so the new sample replaces it without loss
      assign wr[i]     = keep[i] && (!full[i] || gnt[i]);
      assign ovf_ev[i] = keep[i] && full[i] && !gnt[i];
      always_ff @(posedge clk)
         if (rst) begin
            phase[i] <= '0;
            hold[i]  <= '0;
         end else begin
            if (enable && bus.ch_valid[i])
               phase[i] <= (phase[i] == PW'(DECIMATE_FACTOR - 1)) ? '0 : phase[i] + 1'b1;
            if (wr[i]) hold[i] <= bus.ch_data[i*WIDTH +: WIDTH];
         end
   end
   always_ff @(posedge clk)
      if (rst) begin
         full          <= '0;
         overflow      <= '0;
         last_grant    <= CH_W'(NUM_CH - 1);
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_ch    <= '0;
      end else begin
         full     <= wr | (full & ~gnt);
         overflow <= (clear_ovf ? '0 : overflow) | ovf_ev;
         if (out_free) begin
            bus.out_valid <= gnt_any;
            if (gnt_any) begin
               bus.out_data <= hold[gnt_idx];
               bus.out_ch   <= gnt_idx;
               last_grant   <= gnt_idx;
            end
         end
      end
endmodule

// File: tb/tb_decim_channel_scheduler.sv
// tb_decim_channel_scheduler: directed vectors against an M=4 and an M=1 instance
module tb_decim_channel_scheduler;
   logic clk = 1'b0, rst = 1'b1, enable = 1'b1, clear_ovf = 1'b0;
   logic [3:0] ovf4, ovf1;
   int n_chk = 0, n_pass = 0;
   decim_channel_scheduler_if #(.NUM_CH(4), .WIDTH(16)) b4 ();
   decim_channel_scheduler_if #(.NUM_CH(4), .WIDTH(16)) b1 ();
   decim_channel_scheduler #(.NUM_CH(4), .DECIMATE_FACTOR(4), .WIDTH(16)) dut4 (
      .clk(clk), .rst(rst), .enable(enable), .clear_ovf(clear_ovf), .overflow(ovf4), .bus(b4.slave));
   decim_channel_scheduler #(.NUM_CH(4), .DECIMATE_FACTOR(1), .WIDTH(16)) dut1 (
      .clk(clk), .rst(rst), .enable(enable), .clear_ovf(clear_ovf), .overflow(ovf1), .bus(b1.slave));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1);
   end
   initial begin
      b4.ch_valid = '0; b4.ch_data = '0; b4.out_ready = 1'b1;
      b1.ch_valid = '0; b1.ch_data = '0; b1.out_ready = 1'b1;
      tick; tick;
      rst = 1'b0;
      check("rst_valid", b4.out_valid, 0);
      check("rst_data", b4.out_data, 0);
      check("rst_ch", b4.out_ch, 0);
      check("rst_ovf", ovf4, 0);
      check("rst_valid_m1", b1.out_valid, 0);
      // M=4: ch0 strobed every other cycle, every fourth sample kept
      for (int s = 0; s < 16; s++) begin
         b4.ch_valid = 4'b0001;
         b4.ch_data  = {48'h0, 16'(s)};
         tick;
         b4.ch_valid = '0;
         if (s == 0) check("dec_lat1", b4.out_valid, 0);
         tick;
         check("dec_valid", b4.out_valid, (s % 4 == 0) ? 1 : 0);
         if (s % 4 == 0) begin
            check("dec_data", b4.out_data, s);
            check("dec_ch", b4.out_ch, 0);
         end
      end
      // backpressure on ch1
      b4.out_ready = 1'b0;
      for (int k = 0; k < 9; k++) begin
         b4.ch_valid = 4'b0010;
         b4.ch_data  = (k % 4 == 0) ? {32'h0, 16'(16'h0100 * (k / 4 + 1)), 16'h0} : {32'h0, 16'hDEAD, 16'h0};
         tick;
         if (k >= 1) check("bp_hold", b4.out_data, 16'h0100);
         if (k == 7) check("bp_no_ovf", ovf4, 0);
      end
      b4.ch_valid = '0;
      check("bp_ovf", ovf4, 4'b0010);
      check("bp_valid", b4.out_valid, 1);
      repeat (11) tick;
      check("bp_stable", b4.out_data, 16'h0100);
      check("bp_stable_ch", b4.out_ch, 1);
      b4.out_ready = 1'b1;
      tick;
      check("bp_second", b4.out_data, 16'h0200);
      check("bp_second_v", b4.out_valid, 1);
      tick;
      check("bp_empty", b4.out_valid, 0);
      check("bp_ovf_sticky", ovf4, 4'b0010);
      clear_ovf = 1'b1;
      tick;
      clear_ovf = 1'b0;
      check("ovf_clear", ovf4, 0);
      // enable low: ch0 strobes must not advance the phase or write
      enable = 1'b0;
      repeat (3) begin
         b4.ch_valid = 4'b0001;
         b4.ch_data  = {48'h0, 16'h0111};
         tick;
         b4.ch_valid = '0;
         tick;
         check("en_ignored", b4.out_valid, 0);
      end
      enable = 1'b1;
      b4.ch_valid = 4'b0001;
      b4.ch_data  = {48'h0, 16'h0AAA};
      tick;
      b4.ch_valid = '0;
      tick;
      check("en_kept_v", b4.out_valid, 1);
      check("en_kept_d", b4.out_data, 16'h0AAA);
      b4.ch_valid = 4'b0001;
      b4.ch_data  = {48'h0, 16'h0BBB};
      tick;
      b4.ch_valid = '0;
      tick;
      check("en_next_drop", b4.out_valid, 0);
      // M=1: all channels every cycle, rotation and overflow on the starved ones
      for (int k = 0; k < 6; k++) begin
         b1.ch_valid = 4'hF;
         b1.ch_data  = {16'(16'h3000 + k), 16'(16'h2000 + k), 16'(16'h1000 + k), 16'(k)};
         tick;
         if (k == 0) check("rr_lat", b1.out_valid, 0);
         else if (k <= 4) begin
            check("rr_ch", b1.out_ch, k - 1);
            check("rr_data", b1.out_data, (k - 1) * 16'h1000);
         end else begin
            check("rr_wrap_ch", b1.out_ch, 0);
            check("rr_wrap_data", b1.out_data, 1);
         end
         if (k == 1) check("rr_ovf", ovf1, 4'b1110);
      end
      // reset with buffers full and output held
      b1.ch_valid  = '0;
      b1.out_ready = 1'b0;
      check("prerst_valid", b1.out_valid, 1);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      check("mid_rst_valid", b1.out_valid, 0);
      check("mid_rst_ovf", ovf1, 0);
      check("mid_rst_data", b1.out_data, 0);
      b1.out_ready = 1'b1;
      b1.ch_valid  = 4'b0001;
      b1.ch_data   = {48'h0, 16'h0055};
      tick;
      b1.ch_valid = '0;
      check("post_rst_lat", b1.out_valid, 0);
      tick;
      check("post_rst_d", b1.out_data, 16'h0055);
      check("post_rst_ch", b1.out_ch, 0);
      tick;
      check("post_rst_empty", b1.out_valid, 0);
      // ch2 drained and rewritten in one cycle under full load
      b1.ch_valid = 4'hF;
      b1.ch_data  = {16'h0301, 16'h0201, 16'h0101, 16'h0001};
      tick;
      b1.ch_valid = '0;
      check("dw_lat", b1.out_valid, 0);
      tick;
      check("dw_ch1", b1.out_data, 16'h0101);
      b1.ch_valid = 4'hF;
      b1.ch_data  = {16'h0302, 16'h0202, 16'h0102, 16'h0002};
      tick;
      b1.ch_valid = '0;
      check("dw_ch2_old", b1.out_data, 16'h0201);
      check("dw_ovf", ovf1, 4'b1001);
      tick;
      check("dw_ch3", b1.out_data, 16'h0301);
      tick;
      check("dw_ch0", b1.out_data, 16'h0001);
      tick;
      check("dw_ch1_new", b1.out_data, 16'h0102);
      tick;
      check("dw_ch2_new", b1.out_data, 16'h0202);
      check("dw_ch2_tag", b1.out_ch, 2);
      tick;
      check("dw_drained", b1.out_valid, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
